// File: rtl/keypad_decoder.sv
// keypad_decoder
// Reads the 4x4 keypad columns while the row scanner drives one-hot rows.
// Each debounced key press becomes a 4-bit code with a one-cycle strobe.
// Both press and release are debounced, and multi-key chords are rejected.
//
// Ports
//   clk        system clock, shared with the row scanner
//   rst        asynchronous, active-high reset
//   row_sel    {R1,R2,R3,R4} one-hot row drive from the scanner
//   col        {C1,C2,C3,C4} raw active-high columns, asynchronous to clk
//   key_code   4*row_index + col_index of the accepted key (R1/C1 = index 0)
//   key_valid  one-cycle strobe, key_code valid in the same cycle
//   key_held   high from press acceptance until release acceptance
//
// Optional feature: define KEYPAD_REPEAT_EN to build auto-repeat. The first
// repeat comes 2*REPEAT_SCANS scans after acceptance, and later repeats come
// every REPEAT_SCANS scans.
module keypad_decoder #(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_sel,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_db
    $error("keypad_decoder: DEBOUNCE_SCANS must be 1..15");
  end
  if (REPEAT_SCANS < 2 || REPEAT_SCANS > 255) begin : g_bad_rpt
    $error("keypad_decoder: REPEAT_SCANS must be 2..255");
  end

  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_e;

  logic [3:0]  col_s1_q, col_s2_q;   // column synchronizer
  logic [3:0]  row_d1_q, row_d2_q;   // matching row delay
  logic [1:0]  vld_q;                // marks real samples vs post-reset fill
  logic [11:0] snap_q, snap_d;       // R1..R3 slots; R4 uses the live sample
  logic        inv_q;                // current scan saw a bad row drive
  state_e      state_q;
  logic [3:0]  cand_q, cnt_q, key_code_q;
  logic        key_valid_q, key_held_q;

  logic        row_ok, eos, single, match;
  logic [15:0] scan_bits;
  logic [4:0]  hits;
  logic [3:0]  hit_code, cnt_inc;

  // The reset fill of the delay line is not a sample. Without this qualifier,
  // those zero rows would poison the first real scan as invalid.
  assign row_ok = (row_d2_q != 4'd0) && ((row_d2_q & (row_d2_q - 4'd1)) == 4'd0);
  assign eos    = vld_q[1] && (row_d2_q == 4'b0001);

  // Slot for row r / column c is bit 4r+c. col[3] is C1.
  always_comb begin
    snap_d = snap_q;
    if (vld_q[1]) begin
      for (int r = 0; r < 3; r++) begin
        if (row_d2_q[3-r]) begin
          for (int c = 0; c < 4; c++) snap_d[4*r+c] = col_s2_q[3-c];
        end
      end
    end
  end

  // Scan classification. It only matters on end-of-scan cycles.
  always_comb begin
    scan_bits = {col_s2_q[0], col_s2_q[1], col_s2_q[2], col_s2_q[3], snap_q};
    hits      = 5'd0;
    hit_code  = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (scan_bits[k]) begin
        hits     = hits + 5'd1;
        hit_code = 4'(k);
      end
    end
  end

  assign single  = !inv_q && (hits == 5'd1);
  assign match   = single && (hit_code == cand_q);
  assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [8:0] RPT1 = 9'(REPEAT_SCANS);
  localparam logic [8:0] RPT2 = 9'(2 * REPEAT_SCANS);
  logic [8:0] rpt_q, rpt_inc;
  assign rpt_inc = rpt_q + 9'd1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q    <= '0;
      col_s2_q    <= '0;
      row_d1_q    <= '0;
      row_d2_q    <= '0;
      vld_q       <= '0;
      snap_q      <= '0;
      inv_q       <= 1'b0;
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= '0;
`endif
    end else begin
      col_s1_q    <= col;
      col_s2_q    <= col_s1_q;
      row_d1_q    <= row_sel;
      row_d2_q    <= row_d1_q;
      vld_q       <= {vld_q[0], 1'b1};
      snap_q      <= snap_d;
      key_valid_q <= 1'b0;

      if (eos) begin
        inv_q <= 1'b0;
        unique case (state_q)
          IDLE: if (single) begin
            cand_q <= hit_code;
            cnt_q  <= 4'd1;
            if (DB <= 4'd1) begin
              key_code_q  <= hit_code;
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
              state_q     <= PRESSED;
            end else begin
              state_q <= PRESS_DB;
            end
          end
          PRESS_DB: begin
            if (match) begin
              cnt_q <= cnt_inc;
              if (cnt_inc >= DB) begin
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                state_q     <= PRESSED;
              end
            end else if (single) begin
              cand_q <= hit_code;
              cnt_q  <= 4'd1;
            end else begin
              cnt_q   <= 4'd0;
              state_q <= IDLE;
            end
          end
          PRESSED: begin
            if (match) begin
`ifdef KEYPAD_REPEAT_EN
              if (rpt_inc == RPT2) begin
                rpt_q       <= RPT1;
                key_valid_q <= 1'b1;
              end else begin
                rpt_q <= rpt_inc;
              end
`endif
            end else begin
`ifdef KEYPAD_REPEAT_EN
              rpt_q <= '0;
`endif
              cnt_q <= 4'd1;
              if (DB <= 4'd1) begin
                key_held_q <= 1'b0;
                state_q    <= IDLE;
              end else begin
                state_q <= RELEASE_DB;
              end
            end
          end
          RELEASE_DB: begin
            if (match) begin
              state_q <= PRESSED;
            end else begin
              cnt_q <= cnt_inc;
              if (cnt_inc >= DB) begin
                key_held_q <= 1'b0;
                state_q    <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (vld_q[1] && !row_ok) begin
        inv_q <= 1'b1;
      end
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed bench for keypad_decoder (DEBOUNCE_SCANS=4, REPEAT_SCANS=4).
// The bench acts as the row scanner. A scan drives R1..R4 on four negedges.
// The result of scan s becomes visible two edges after the R1 of scan s+1.
// For that reason, every observation is filed against the scan in progress.
module tb_keypad_decoder;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_sel, col;
  logic [3:0] key_code;
  logic       key_valid, key_held;

  always #5 clk = ~clk;

  keypad_decoder #(.DEBOUNCE_SCANS(4), .REPEAT_SCANS(4)) dut (
    .clk(clk), .rst(rst), .row_sel(row_sel), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  int         n_chk = 0, n_fail = 0;
  int         sc = 0;
  int         vcnt [0:511];
  logic [3:0] vcode[0:511];
  logic       held2[0:511];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // keys bit k = key with code k pressed. rst_on/rst_off give the phase at
  // which rst is raised or dropped (-1 = leave it alone).
  task automatic scan(input logic [15:0] keys, input int rst_on = -1, input int rst_off = -1);
    sc++;
    vcnt[sc]  = 0;
    vcode[sc] = 4'd0;
    held2[sc] = 1'b0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        vcnt[sc]  = vcnt[sc] + 1;
        vcode[sc] = key_code;
      end
      if (r == 2) held2[sc] = key_held;
      if (rst) begin
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_held",  {31'd0, key_held},  32'd0);
        chk("rst_code",  {28'd0, key_code},  32'd0);
      end
      if (r == rst_on)  rst = 1'b1;
      if (r == rst_off) rst = 1'b0;
      row_sel = 4'b1000 >> r;
      col     = {keys[4*r], keys[4*r+1], keys[4*r+2], keys[4*r+3]};
    end
  endtask

  function automatic int pulses(input int a, input int b);
    int n = 0;
    for (int s = a; s <= b; s++) n += vcnt[s];
    return n;
  endfunction

  int s0, s1;

  initial begin
    rst = 1'b1; row_sel = 4'd0; col = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_code",  {28'd0, key_code},  32'd0);
    chk("reset_valid", {31'd0, key_valid}, 32'd0);
    chk("reset_held",  {31'd0, key_held},  32'd0);
    rst = 1'b0;
    repeat (2) scan(16'h0000);

    // Code 6 (R2/C3) for 8 scans, then released.
    s0 = sc + 1;
    repeat (8) scan(16'h0040);
    repeat (6) scan(16'h0000);
    chk("t1_pulses",   pulses(s0, s0 + 13), 1);
    chk("t1_at_scan4", vcnt[s0+4], 1);
    chk("t1_code",     {28'd0, vcode[s0+4]}, 32'd6);
    chk("t1_held_pre", {31'd0, held2[s0+3]},  32'd0);
    chk("t1_held_on",  {31'd0, held2[s0+4]},  32'd1);
    chk("t1_held_rel3",{31'd0, held2[s0+11]}, 32'd1);
    chk("t1_held_off", {31'd0, held2[s0+12]}, 32'd0);

    // Code 15 (R4/C4) bouncing every scan.
    s0 = sc + 1;
    for (int i = 0; i < 20; i++) scan((i % 2 == 0) ? 16'h8000 : 16'h0000);
    repeat (6) scan(16'h0000);
    chk("t2_pulses", pulses(s0, s0 + 25), 0);
    begin
      int h = 0;
      for (int s = s0; s <= s0 + 25; s++) h += int'(held2[s]);
      chk("t2_held", h, 0);
    end

    // Chord of code 0 + code 9, then code 9 is released.
    s0 = sc + 1;
    repeat (10) scan(16'h0201);
    s1 = sc + 1;
    repeat (6) scan(16'h0001);
    repeat (6) scan(16'h0000);
    chk("t3_chord_quiet", pulses(s0, s1), 0);
    chk("t3_at_scan4",    vcnt[s1+4], 1);
    chk("t3_code",        {28'd0, vcode[s1+4]}, 32'd0);
    chk("t3_pulses",      pulses(s0, sc), 1);

    // Code 1 for 3 scans, then switch to code 2.
    s0 = sc + 1;
    repeat (3) scan(16'h0002);
    s1 = sc + 1;
    repeat (6) scan(16'h0004);
    repeat (6) scan(16'h0000);
    chk("t4_pulses",   pulses(s0, sc), 1);
    chk("t4_at_scan4", vcnt[s1+4], 1);
    chk("t4_code",     {28'd0, vcode[s1+4]}, 32'd2);

    // Code 10 held; rst for 2 cycles in PRESS_DB at cnt=3.
    s0 = sc + 1;
    repeat (3) scan(16'h0400);
    scan(16'h0400, 2, -1);
    scan(16'h0400, -1, 0);
    repeat (8) scan(16'h0400);
    repeat (6) scan(16'h0000);
    chk("t5_no_early", pulses(s0, s0 + 7), 0);
    chk("t5_at_scan",  vcnt[s0+8], 1);
    chk("t5_code",     {28'd0, vcode[s0+8]}, 32'd10);
    chk("t5_pulses",   pulses(s0, sc), 1);

    // Code 5 held for 20 scans.
    s0 = sc + 1;
    repeat (20) scan(16'h0020);
    repeat (6) scan(16'h0000);
    chk("t6_accept", vcnt[s0+4], 1);
    chk("t6_code",   {28'd0, vcode[s0+4]}, 32'd5);
`ifdef KEYPAD_REPEAT_EN
    chk("t6_rpt8",   vcnt[s0+12], 1);
    chk("t6_rpt12",  vcnt[s0+16], 1);
    chk("t6_rpt16",  vcnt[s0+20], 1);
    chk("t6_pulses", pulses(s0, sc), 4);
`else
    chk("t6_pulses", pulses(s0, sc), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
